// File: rtl/psd_pkg.sv
// Shared FSM encoding and default geometry for the point-set driver.
package psd_pkg;

  localparam int DW_DEF       = 8;
  localparam int SET_LEN_DEF  = 6;
  localparam int NUM_SETS_DEF = 3;
  localparam int TOTAL        = SET_LEN_DEF * NUM_SETS_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GAP     = 3'd1,
    SEND    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/psd_pattern_mem.sv
// Input and golden pattern tables: one shared write port, two combinational reads.
// Contents are deliberately not reset so a board can load once and rerun many times.
module psd_pattern_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 18,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic            sel_gold,
  input  logic [AW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [AW-1:0]   in_raddr,
  output logic [2*DW-1:0] in_rdata,
  input  logic [AW-1:0]   gold_raddr,
  output logic [2*DW-1:0] gold_rdata
);

  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

  logic [2*DW-1:0] in_mem_r   [DEPTH];
  logic [2*DW-1:0] gold_mem_r [DEPTH];

  // Table write; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (we && (waddr <= LAST_A)) begin
      if (sel_gold) begin
        gold_mem_r[waddr] <= wdata;
      end else begin
        in_mem_r[waddr] <= wdata;
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    in_rdata   = {(2*DW){1'b0}};
    gold_rdata = {(2*DW){1'b0}};
    if (in_raddr <= LAST_A) begin
      in_rdata = in_mem_r[in_raddr];
    end else begin
      in_rdata = {(2*DW){1'b0}};
    end
    if (gold_raddr <= LAST_A) begin
      gold_rdata = gold_mem_r[gold_raddr];
    end else begin
      gold_rdata = {(2*DW){1'b0}};
    end
  end

endmodule

// File: rtl/point_set_driver.sv
// Self-test host for the point-set engine: streams pattern bursts, checks results.
// Optional collect watchdog enabled by defining PSD_TIMEOUT_EN.
module point_set_driver
  import psd_pkg::*;
#(
  parameter int  DW          = DW_DEF,
  parameter int  SET_LEN     = SET_LEN_DEF,
  parameter int  NUM_SETS    = NUM_SETS_DEF,
  parameter int  TIMEOUT_CYC = 1024,
  localparam int AW          = $clog2(NUM_SETS * SET_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_we,
  input  logic          load_gold,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_x,
  input  logic [DW-1:0] load_y,
  input  logic          start,
  output logic          give_valid,
  output logic [DW-1:0] dataX,
  output logic [DW-1:0] dataY,
  input  logic          out_valid,
  input  logic [DW-1:0] ansX,
  input  logic [DW-1:0] ansY,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   correct_cnt,
  output logic          mism,
  output logic [AW-1:0] mism_set,
  output logic          timeout
);

  localparam int            N_PTS     = SET_LEN * NUM_SETS;
  localparam logic [AW-1:0] SET_LEN_A = AW'(SET_LEN);
  localparam logic [AW-1:0] IDX_LAST  = AW'(SET_LEN - 1);
  localparam logic [AW-1:0] SET_LAST  = AW'(NUM_SETS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(N_PTS);

  state_t          state_r, state_s;
  logic [AW-1:0]   set_r, k_r, res_r;
  logic            fail_r;
  logic [2*DW-1:0] in_word_s, gold_word_s;
  logic [AW-1:0]   in_addr_s, gold_addr_s;
  logic            run_s, start_ok_s, hit_s, match_s;
  logic            last_k_s, last_res_s, last_set_s, wd_expire_s;
  logic            give_valid_s, busy_s, done_s;
  logic            fail_nx_s, to_nx_s;
  logic [AW:0]     cnt_nx_s;

  assign run_s       = (state_r == GAP) || (state_r == SEND) || (state_r == COLLECT);
  assign start_ok_s  = start && !run_s;
  assign in_addr_s   = set_r * SET_LEN_A + k_r;
  assign gold_addr_s = set_r * SET_LEN_A + res_r;
  assign hit_s       = (state_r == COLLECT) && out_valid;
  assign match_s     = (ansX == gold_word_s[2*DW-1:DW]) && (ansY == gold_word_s[DW-1:0]);
  assign last_k_s    = (k_r == IDX_LAST);
  assign last_res_s  = (res_r == IDX_LAST);
  assign last_set_s  = (set_r == SET_LAST);

  psd_pattern_mem #(.DW(DW), .DEPTH(N_PTS), .AW(AW)) u_mem (
    .clk        (clk),
    .we         (load_we && !run_s),
    .sel_gold   (load_gold),
    .waddr      (load_addr),
    .wdata      ({load_x, load_y}),
    .in_raddr   (in_addr_s),
    .in_rdata   (in_word_s),
    .gold_raddr (gold_addr_s),
    .gold_rdata (gold_word_s)
  );

`ifdef PSD_TIMEOUT_EN
  localparam int             WDW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  logic [WDW-1:0] wd_r;

  // Idle-cycle counter while collecting; any result restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_r <= {WDW{1'b0}};
    end else if ((state_r == COLLECT) && !out_valid) begin
      wd_r <= wd_r + WDW'(1);
    end else begin
      wd_r <= {WDW{1'b0}};
    end
  end

  assign wd_expire_s = (state_r == COLLECT) && !out_valid && (wd_r == WD_LAST);
`else
  assign wd_expire_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? GAP : IDLE;
      GAP:     state_s = SEND;
      SEND:    state_s = last_k_s ? COLLECT : SEND;
      COLLECT: begin
        if (wd_expire_s) begin
          state_s = DONE;
        end else if (hit_s && last_res_s) begin
          state_s = last_set_s ? DONE : GAP;
        end else begin
          state_s = COLLECT;
        end
      end
      DONE:    state_s = start ? GAP : DONE;
      default: state_s = IDLE;
    endcase
  end

  // Output and status decode; status is evaluated against the post-edge state.
  always_comb begin
    give_valid_s = (state_r == SEND);
    busy_s       = (state_s == GAP) || (state_s == SEND) || (state_s == COLLECT);
    done_s       = (state_s == DONE);
    cnt_nx_s     = correct_cnt;
    fail_nx_s    = fail_r;
    to_nx_s      = timeout;
    if (start_ok_s) begin
      cnt_nx_s  = {(AW+1){1'b0}};
      fail_nx_s = 1'b0;
      to_nx_s   = 1'b0;
    end else begin
      if (hit_s && match_s && (correct_cnt != CNT_FULL)) begin
        cnt_nx_s = correct_cnt + (AW+1)'(1);
      end else begin
        cnt_nx_s = correct_cnt;
      end
      fail_nx_s = fail_r || (hit_s && !match_s);
      to_nx_s   = timeout || wd_expire_s;
    end
  end

  // Burst index, result index and set counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      set_r  <= {AW{1'b0}};
      k_r    <= {AW{1'b0}};
      res_r  <= {AW{1'b0}};
      fail_r <= 1'b0;
    end else begin
      fail_r <= fail_nx_s;
      if (state_r == SEND) begin
        k_r <= last_k_s ? {AW{1'b0}} : k_r + AW'(1);
      end else begin
        k_r <= {AW{1'b0}};
      end
      if (start_ok_s) begin
        set_r <= {AW{1'b0}};
        res_r <= {AW{1'b0}};
      end else if (hit_s) begin
        res_r <= last_res_s ? {AW{1'b0}} : res_r + AW'(1);
        if (last_res_s && !last_set_s) begin
          set_r <= set_r + AW'(1);
        end
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      give_valid  <= 1'b0;
      dataX       <= {DW{1'b0}};
      dataY       <= {DW{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      correct_cnt <= {(AW+1){1'b0}};
      mism        <= 1'b0;
      mism_set    <= {AW{1'b0}};
      timeout     <= 1'b0;
    end else begin
      give_valid  <= give_valid_s;
      if (give_valid_s) begin
        dataX <= in_word_s[2*DW-1:DW];
        dataY <= in_word_s[DW-1:0];
      end
      busy        <= busy_s;
      done        <= done_s;
      pass        <= done_s && !fail_nx_s && !to_nx_s && (cnt_nx_s == CNT_FULL);
      correct_cnt <= cnt_nx_s;
      mism        <= hit_s && !match_s;
      if (hit_s && !match_s) begin
        mism_set <= set_r;
      end
      timeout     <= to_nx_s;
    end
  end

endmodule

// File: tb/tb_point_set_driver.sv
// Scoreboard bench for point_set_driver with an echo-engine stub.
`timescale 1ns/1ps
module tb_point_set_driver;
  import psd_pkg::*;

  localparam int DW = 8;
  localparam int SL = 6;
  localparam int NS = 3;
  localparam int AW = $clog2(SL * NS);
`ifdef PSD_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  typedef struct packed { logic [DW-1:0] x; logic [DW-1:0] y; } pt_t;
  typedef struct packed { logic p; logic [AW:0] cnt; logic to; } res_t;

  logic          clk = 1'b0, reset = 1'b1, load_we = 1'b0, load_gold = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_x = '0, load_y = '0, ansX = '0, ansY = '0;
  logic          start = 1'b0, out_valid = 1'b0;
  logic          give_valid, busy, done, pass, mism, timeout;
  logic [DW-1:0] dataX, dataY;
  logic [AW:0]   correct_cnt;
  logic [AW-1:0] mism_set;

  point_set_driver #(.DW(DW), .SET_LEN(SL), .NUM_SETS(NS), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .load_we(load_we), .load_gold(load_gold),
    .load_addr(load_addr), .load_x(load_x), .load_y(load_y), .start(start),
    .give_valid(give_valid), .dataX(dataX), .dataY(dataY), .out_valid(out_valid),
    .ansX(ansX), .ansY(ansY), .busy(busy), .done(done), .pass(pass),
    .correct_cnt(correct_cnt), .mism(mism), .mism_set(mism_set), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  pt_t  exp_pts[$];
  int   exp_mism[$];
  res_t exp_res[$];
  logic [DW-1:0] tx [TOTAL];
  logic [DW-1:0] ty [TOTAL];

  // stub state
  pt_t  sbuf[$];
  int   bad_idx = -1, res_idx = 0, wait_c = 0;
  logic [DW-1:0] bad_dy = '0;
  bit   stall = 0, stall_ph = 0, mute = 0, inj_req = 0;

  // monitor state
  int   blen = 0;
  bit   pdone = 0;
  pt_t  ep;
  res_t er;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Engine stub: buffers each burst and replays it 3 cycles after the burst ends.
  initial begin
    forever begin
      @(negedge clk);
      out_valid = 1'b0;
      if (reset) begin
        sbuf.delete();
        wait_c = 0;
      end else begin
        if (give_valid) begin
          sbuf.push_back({dataX, dataY});
          wait_c = 3;
        end else if (wait_c > 0) begin
          wait_c--;
        end else if (sbuf.size() > 0 && !mute) begin
          stall_ph = !stall_ph;
          if (!stall || stall_ph) begin
            pt_t p;
            p = sbuf.pop_front();
            out_valid = 1'b1;
            ansX = p.x;
            ansY = (res_idx == bad_idx) ? p.y + bad_dy : p.y;
            res_idx++;
          end
        end
        if (inj_req) begin
          out_valid = 1'b1;
          ansX = tx[0];
          ansY = ty[0];
          inj_req = 0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents points, mismatches or done.
  initial begin
    forever begin
      @(negedge clk);
      if (give_valid) begin
        blen++;
        chk("point_expected", int'(exp_pts.size() > 0), 1);
        if (exp_pts.size() > 0) begin
          ep = exp_pts.pop_front();
          chk("dataX", int'(dataX), int'(ep.x));
          chk("dataY", int'(dataY), int'(ep.y));
        end
      end else if (blen != 0) begin
        if (!reset) chk("burst_len", blen, SL);
        blen = 0;
      end
      if (mism) begin
        chk("mism_expected", int'(exp_mism.size() > 0), 1);
        if (exp_mism.size() > 0) chk("mism_set", int'(mism_set), exp_mism.pop_front());
      end
      if (done && !pdone) begin
        chk("done_expected", int'(exp_res.size() > 0), 1);
        if (exp_res.size() > 0) begin
          er = exp_res.pop_front();
          chk("pass", int'(pass), int'(er.p));
          chk("correct_cnt", int'(correct_cnt), int'(er.cnt));
          chk("timeout", int'(timeout), int'(er.to));
          chk("busy_at_done", int'(busy), 0);
        end
      end
      pdone = done;
    end
  end

  task automatic load_tables();
    for (int i = 0; i < TOTAL; i++) begin
      for (int g = 0; g < 2; g++) begin
        load_we = 1'b1; load_gold = (g == 1); load_addr = AW'(i);
        load_x = tx[i]; load_y = ty[i];
        @(negedge clk);
      end
    end
    load_we = 1'b0;
  endtask

  task automatic go(input int bad, input logic [DW-1:0] dy, input bit stl, input int npts,
                    input int mset, input bit epass, input int ecnt, input bit eto);
    bad_idx = bad; bad_dy = dy; stall = stl; res_idx = 0;
    for (int i = 0; i < npts; i++) exp_pts.push_back({tx[i], ty[i]});
    if (mset >= 0) exp_mism.push_back(mset);
    exp_res.push_back({epass, (AW+1)'(ecnt), eto});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished"}, int'(done), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < TOTAL; i++) begin
      tx[i] = 8'(i * 7 + 3);
      ty[i] = 8'(i * 13 + 1);
    end
    tx[9]  = 8'd5; ty[9]  = 8'd8;
    tx[14] = 8'd7; ty[14] = 8'd4;

    repeat (3) @(negedge clk);
    chk("rst_give_valid", int'(give_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_correct_cnt", int'(correct_cnt), 0);
    chk("rst_mism", int'(mism), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    @(negedge clk);
    load_tables();

    // clean run
    go(-1, 8'd0, 0, TOTAL, -1, 1, TOTAL, 0);
    wait_done("clean");
    // set 1, result 3: (5,9) against golden (5,8)
    go(9, 8'd1, 0, TOTAL, 1, 0, TOTAL - 1, 0);
    wait_done("bad_y_set1");
    // only ansY wrong: (7,3) against golden (7,4), with stalls between results
    go(14, 8'hFF, 1, TOTAL, 2, 0, TOTAL - 1, 0);
    wait_done("bad_y_set2");

    // reset during SEND of set 1
    bad_idx = -1; stall = 0; res_idx = 0;
    for (int i = 0; i < TOTAL; i++) exp_pts.push_back({tx[i], ty[i]});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (exp_pts.size() > 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_set1_send", int'(exp_pts.size() <= 10), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_give_valid", int'(give_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_correct_cnt", int'(correct_cnt), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_pts.delete();
    @(negedge clk);
    go(-1, 8'd0, 0, TOTAL, -1, 1, TOTAL, 0);
    wait_done("rerun");

    // out_valid during SEND, start and load_we while busy
    go(-1, 8'd0, 0, TOTAL, -1, 1, TOTAL, 0);
    n = 0;
    while (!give_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    inj_req = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_we = 1'b1; load_gold = 1'b0; load_addr = AW'(2); load_x = 8'hEE; load_y = 8'hEE;
    @(negedge clk);
    load_gold = 1'b1; load_addr = AW'(3);
    @(negedge clk);
    load_we = 1'b0;
    wait_done("busy_ignore");
    go(-1, 8'd0, 1, TOTAL, -1, 1, TOTAL, 0);
    wait_done("tables_unchanged");

`ifdef PSD_TIMEOUT_EN
    mute = 1;
    go(-1, 8'd0, 0, SL, -1, 0, 0, 1);
    wait_done("watchdog");
    mute = 0;
    sbuf.delete();
`endif

    chk("points_left", exp_pts.size(), 0);
    chk("mism_left", exp_mism.size(), 0);
    chk("done_left", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
